// File: rtl/gpio_bus_arbiter.sv
// gpio_bus_arbiter: shares the GPIO register port between two bus masters.
// Round-robin arbitration with a registered grant. Each transaction runs
// IDLE/RESP -> ACCESS (gnt, GPIO port driven) -> RESP (done, rdata valid).
// Optional feature: define GPIO_ARB_LOCK_EN to add lock0/lock1 inputs that let
// the current owner keep the port for atomic read-modify-write sequences.
module gpio_bus_arbiter #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 2,
  parameter bit RR_INIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wd0,
  input  logic [DATA_W-1:0] wd1,
`ifdef GPIO_ARB_LOCK_EN
  input  logic              lock0,
  input  logic              lock1,
`endif
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              gpio_we,
  output logic [ADDR_W-1:0] gpio_addr,
  output logic [DATA_W-1:0] gpio_wd,
  input  logic [DATA_W-1:0] gpio_rd
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   rr_ptr;
  logic   rr_nxt;
  logic   owner;
  logic   eff_ptr;
  logic   lock_hold;
  logic   win_valid;
  logic   win_id;

  // Lock retention and effective priority: in RESP the non-owner is favoured.
  always_comb begin
    lock_hold = 1'b0;
`ifdef GPIO_ARB_LOCK_EN
    if (state == RESP) begin
      if (owner) begin
        lock_hold = lock1 & req1;
      end else begin
        lock_hold = lock0 & req0;
      end
    end else begin
      lock_hold = 1'b0;
    end
`endif
    if (state == RESP) begin
      eff_ptr = ~owner;
    end else begin
      eff_ptr = rr_ptr;
    end
  end

  // Next-state, round-robin pointer update and arbitration decision.
  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    win_valid = 1'b0;
    win_id    = 1'b0;
    case (state)
      IDLE, RESP: begin
        if ((state == RESP) && !lock_hold) begin
          rr_nxt = ~owner;
        end else begin
          rr_nxt = rr_ptr;
        end
        if (lock_hold) begin
          win_valid = 1'b1;
          win_id    = owner;
        end else if (req0 && req1) begin
          win_valid = 1'b1;
          win_id    = eff_ptr;
        end else if (req0) begin
          win_valid = 1'b1;
          win_id    = 1'b0;
        end else if (req1) begin
          win_valid = 1'b1;
          win_id    = 1'b1;
        end else begin
          win_valid = 1'b0;
          win_id    = 1'b0;
        end
        if (win_valid) begin
          state_nxt = ACCESS;
        end else begin
          state_nxt = IDLE;
        end
      end
      ACCESS: begin
        state_nxt = RESP;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and round-robin pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= RR_INIT;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_nxt;
    end
  end

  // Command capture, registered grant/done pulses, GPIO port and read data.
  // gpio_addr/gpio_wd are the captured command registers; gpio_we holds the
  // captured write flag for the single ACCESS cycle only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      gpio_we   <= 1'b0;
      gpio_addr <= {ADDR_W{1'b0}};
      gpio_wd   <= {DATA_W{1'b0}};
      rdata     <= {DATA_W{1'b0}};
    end else begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      gpio_we <= 1'b0;
      if (win_valid) begin
        owner     <= win_id;
        gnt0      <= ~win_id;
        gnt1      <= win_id;
        gpio_we   <= win_id ? we1 : we0;
        gpio_addr <= win_id ? addr1 : addr0;
        gpio_wd   <= win_id ? wd1 : wd0;
      end
      if (state == ACCESS) begin
        done0 <= ~owner;
        done1 <= owner;
        if (gpio_we) begin
          rdata <= {DATA_W{1'b0}};
        end else begin
          rdata <= gpio_rd;
        end
      end
    end
  end

endmodule
